scan_sequencer: RTL and testbench
=================================

Name: scan_sequencer

Overview:
- Upstream driver for the 1-to-8 demultiplexer stage.
- Time-multiplexes an 8-bit frame across the eight demux output lines.
- Steps the 3-bit select through 0..7 at a programmable slot rate.
- Inserts a blanking gap at the start of every slot to suppress ghosting, and swaps in new frames only at frame boundaries.

Parameters:
- PRESCALE, 8, clock cycles per slot; legal range PRESCALE >= BLANK+1 and PRESCALE >= 2.
- BLANK, 1, cycles per slot with enable held low at slot start; 0 disables blanking.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- run  input  1  level; 1 = scan continuously, 0 = stop at end of current slot.
- load  input  1  single-cycle strobe; capture frame_data.
- frame_data  input  8  bit k is the value driven while select == k.
- select  output  3  to demux select.
- enable  output  1  to demux enable.
- demux_in  output  1  to demux data input.
- busy  output  1  high while not in IDLE.
- frame_done  output  1  one-cycle pulse after slot 7 completes.

Behaviour:
- All outputs are registered.
- Reset (async assert, sync release) forces: select=0, enable=0, demux_in=0, busy=0, frame_done=0, state=IDLE, slot counter=0, active frame=0, pending frame=0, pending_valid=0.
- States:
  - IDLE: enable=0, select=0, busy=0. With run=1, go to BLANK (or DRIVE if BLANK=0) on the next edge with select=0 and counter=0.
  - BLANK: enable=0, demux_in=0, lasts BLANK cycles, then go to DRIVE.
  - DRIVE: enable=1, demux_in=active[select], lasts PRESCALE-BLANK cycles.
- Slot end (last DRIVE cycle), on the next edge:
  - If run=1: select increments mod 8 (7 wraps to 0) and state returns to BLANK (or stays in DRIVE if BLANK=0).
  - If run=0: go to IDLE with select=0 and enable=0.
- The counter is $clog2(PRESCALE) bits; it resets to 0 at every slot start and never free-runs past PRESCALE-1.
- frame_done is high for exactly the one cycle following the slot-7 end edge. This holds even when run=0 causes entry to IDLE.
- Load handling:
  - Load in IDLE: active <= frame_data on that edge.
  - Load while busy: pending <= frame_data and pending_valid <= 1. A later load before the boundary overwrites pending (last one wins).
  - At the slot-7 end edge, active takes the new frame: frame_data if load is high in that same cycle, otherwise pending if pending_valid. pending_valid then clears.
  - active never changes mid-frame (no tearing).
- Stopping at a slot end other than slot 7 leaves pending_valid set. The pending frame is applied to active on IDLE entry.
- run toggling mid-slot has no effect until the slot end. Re-asserting run while in IDLE restarts at slot 0.
- Reset mid-slot immediately drops enable/demux_in to 0 (asynchronous) and discards pending.
- Invariant: enable and demux_in never change within the same cycle as a select change without passing through enable=0 when BLANK>=1.

Test Plan:
- PRESCALE=4, BLANK=1: reset, load 8'hA5, run=1.
  - Required: per slot, 1 cycle enable=0 then 3 cycles enable=1.
  - demux_in pattern over slots 0..7 is 1,0,1,0,0,1,0,1.
  - frame_done pulses at cycle 32 after scan start, and select wraps to 0.
- Mid-frame load: during slot 3 of frame 8'hFF, load 8'h00.
  - Required: slots 4..7 still drive 1; frame 2 drives all 0.
  - Two loads (8'h0F then 8'hF0) within one frame: frame 2 uses 8'hF0.
- Boundary coincidence: pending=8'h11, then load 8'h22 on the slot-7 end cycle.
  - Required: next frame uses 8'h22 and pending_valid clears.
- Stop: deassert run in slot 5 cycle 1.
  - Required: slot 5 completes, then IDLE with select=0, enable=0, busy=0, and no frame_done.
  - Deassert in slot 7: frame_done pulses once, then IDLE.
- BLANK=0, PRESCALE=2: enable stays continuously 1 across slots, and select advances every 2 cycles.
- Async reset: assert reset_n low mid-DRIVE between clock edges.
  - Required: enable, demux_in and busy go 0 immediately.
  - After release with run=1, scanning restarts at slot 0 with active=0.

Source files
------------

// File: rtl/scan_sequencer.sv
// scan_sequencer: time-multiplexes an 8-bit frame onto a 1-to-8 demux.
// Each slot is PRESCALE cycles: BLANK cycles with enable low, then the
// remaining cycles driving active[select]. New frames are swapped in only
// at the end of slot 7 (or when the scan stops), so a frame never tears.
module scan_sequencer #(
    parameter int PRESCALE = 8,
    parameter int BLANK    = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic       load,
    input  logic [7:0] frame_data,
    output logic [2:0] select,
    output logic       enable,
    output logic       demux_in,
    output logic       busy,
    output logic       frame_done
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] PRE_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    // With no blanking configured a slot starts directly in DRIVE.
    localparam state_t SLOT_START = (BLANK > 0) ? S_BLANK : S_DRIVE;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    sel_q, sel_d;
    logic [7:0]    act_q, act_d;
    logic [7:0]    pend_q, pend_d;
    logic          pvld_q, pvld_d;
    logic          en_q, en_d;
    logic          din_q, din_d;
    logic          busy_q, busy_d;
    logic          fdone_q, fdone_d;

    logic          slot_end;
    logic [7:0]    new_frame;

    // Last DRIVE cycle of the slot; the following edge is the slot boundary.
    assign slot_end = (state_q == S_DRIVE) && (cnt_q == PRE_LAST);

    // Frame to install at a swap point: a same-cycle load beats pending.
    assign new_frame = load ? frame_data : (pvld_q ? pend_q : act_q);

    // State and datapath registers; reset also discards any pending frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= 3'd0;
            act_q   <= 8'h00;
            pend_q  <= 8'h00;
            pvld_q  <= 1'b0;
            en_q    <= 1'b0;
            din_q   <= 1'b0;
            busy_q  <= 1'b0;
            fdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            pvld_q  <= pvld_d;
            en_q    <= en_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            fdone_q <= fdone_d;
        end
    end

    // Next-state, slot counting, frame buffering and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        act_d   = act_q;
        pend_d  = pend_q;
        pvld_d  = pvld_q;
        fdone_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                sel_d = 3'd0;
                // Idle loads go straight to the active frame.
                if (load) act_d = frame_data;
                if (run) state_d = SLOT_START;
            end

            S_BLANK: begin
                if (load) begin
                    pend_d = frame_data;
                    pvld_d = 1'b1;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == BLANK_LAST) state_d = S_DRIVE;
            end

            S_DRIVE: begin
                if (load) begin
                    pend_d = frame_data;
                    pvld_d = 1'b1;
                end
                if (slot_end) begin
                    cnt_d = '0;
                    // Frame boundary: swap frames and consume the pending slot.
                    if (sel_q == 3'd7) begin
                        act_d   = new_frame;
                        pvld_d  = 1'b0;
                        fdone_d = 1'b1;
                    end
                    if (run) begin
                        sel_d   = sel_q + 3'd1;
                        state_d = SLOT_START;
                    end else begin
                        // Stopping early still applies the waiting frame so the
                        // next scan starts with it; pending_valid stays as is.
                        sel_d   = 3'd0;
                        state_d = S_IDLE;
                        if (sel_q != 3'd7) act_d = new_frame;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                sel_d   = 3'd0;
            end
        endcase

        // Outputs are decoded from the next state so they register in step
        // with it; enable drops on the same edge that moves select.
        en_d   = (state_d == S_DRIVE);
        din_d  = en_d & act_d[sel_d];
        busy_d = (state_d != S_IDLE);
    end

    assign select     = sel_q;
    assign enable     = en_q;
    assign demux_in   = din_q;
    assign busy       = busy_q;
    assign frame_done = fdone_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: two instances (PRESCALE=4/BLANK=1 and
// PRESCALE=2/BLANK=0) share stimulus; each is compared every cycle against a
// slot/position model, plus directed checks from the scan rules.
module tb_scan_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       run = 1'b0;
    logic       load = 1'b0;
    logic [7:0] fdata = 8'h00;

    logic [2:0] selA, selB;
    logic       enA, dinA, busyA, fdA;
    logic       enB, dinB, busyB, fdB;

    int checks = 0;
    int failures = 0;

    scan_sequencer #(.PRESCALE(4), .BLANK(1)) dutA (
        .clk(clk), .reset_n(reset_n), .run(run), .load(load), .frame_data(fdata),
        .select(selA), .enable(enA), .demux_in(dinA), .busy(busyA), .frame_done(fdA)
    );

    scan_sequencer #(.PRESCALE(2), .BLANK(0)) dutB (
        .clk(clk), .reset_n(reset_n), .run(run), .load(load), .frame_data(fdata),
        .select(selB), .enable(enB), .demux_in(dinB), .busy(busyB), .frame_done(fdB)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Scan model: busy flag, current slot, cycle within slot, frames.
    typedef struct {
        bit       busy;
        int       slot;
        int       t;
        bit [7:0] act;
        bit [7:0] pend;
        bit       pvld;
        bit       fd;
    } mstate_t;

    mstate_t mA, mB;

    function automatic mstate_t minit();
        mstate_t s;
        s.busy = 0; s.slot = 0; s.t = 0; s.act = 0; s.pend = 0; s.pvld = 0; s.fd = 0;
        return s;
    endfunction

    function automatic mstate_t mstep(mstate_t s, int P, bit r, bit ld, bit [7:0] d);
        mstate_t  n;
        bit [7:0] swap;
        n = s;
        n.fd = 0;
        if (!s.busy) begin
            if (ld) n.act = d;
            if (r) begin n.busy = 1; n.slot = 0; n.t = 0; end
        end else begin
            if (ld) begin n.pend = d; n.pvld = 1; end
            if (s.t == P - 1) begin
                swap = ld ? d : (s.pvld ? s.pend : s.act);
                n.t = 0;
                if (s.slot == 7) begin n.act = swap; n.pvld = 0; n.fd = 1; end
                if (r) n.slot = (s.slot + 1) % 8;
                else begin
                    n.busy = 0; n.slot = 0;
                    if (s.slot != 7) n.act = swap;
                end
            end else begin
                n.t = s.t + 1;
            end
        end
        return n;
    endfunction

    // {select, enable, demux_in, busy, frame_done}
    function automatic logic [6:0] mout(mstate_t s, int B);
        bit en;
        en = s.busy && (s.t >= B);
        return {3'(s.busy ? s.slot : 0), en, en & s.act[s.slot], s.busy, s.fd};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance models on the edge, then compare both instances.
    task automatic cyc();
        mstate_t nA, nB;
        nA = mstep(mA, 4, run, load, fdata);
        nB = mstep(mB, 2, run, load, fdata);
        @(posedge clk);
        #2;
        mA = nA;
        mB = nB;
        chk("outA", {25'd0, selA, enA, dinA, busyA, fdA}, {25'd0, mout(mA, 1)});
        chk("outB", {25'd0, selB, enB, dinB, busyB, fdB}, {25'd0, mout(mB, 0)});
    endtask

    task automatic strobe(input logic [7:0] d);
        load = 1'b1;
        fdata = d;
        cyc();
        load = 1'b0;
    endtask

    // Advance at least one cycle until instance A sits at (slot, cycle).
    task automatic wait_pos(input int sl, input int t);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!(mA.busy && mA.slot == sl && mA.t == t) && n < 200);
        chk("wait_pos_timeout", {31'd0, n >= 200}, 32'd0);
    endtask

    initial begin
        bit [7:0] pat;
        int       fdc, cnt, gaps;

        mA = minit();
        mB = minit();

        // Reset held, then released away from the clock edge.
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();
        chk("reset_state", {25'd0, selA, enA, dinA, busyA, fdA}, 32'd0);

        // Idle load of A5, then scan one full frame.
        strobe(8'hA5);
        run = 1'b1;
        cyc();
        pat = 8'h00; fdc = -1; gaps = 0;
        for (int c = 1; c <= 40; c++) begin
            cyc();
            if (c < 32 && (c % 4) != 0) pat[c / 4] = dinA;
            if (fdA && fdc < 0) fdc = c;
            if (c == 32) chk("wrap_select", {29'd0, selA}, 32'd0);
            if (busyB && !enB) gaps++;
        end
        chk("a5_pattern", {24'd0, pat}, 32'h0000_00A5);
        chk("frame_done_cycle", fdc, 32);
        chk("noblank_enable_gaps", gaps, 0);

        // Mid-frame load must not tear the running frame.
        strobe(8'hFF);
        wait_pos(0, 1);
        wait_pos(3, 1);
        strobe(8'h00);
        wait_pos(5, 2);
        chk("no_tear_slot5", {31'd0, dinA}, 32'd1);
        wait_pos(5, 2);
        chk("next_frame_zero", {31'd0, dinA}, 32'd0);

        // Two loads in one frame: the later one wins.
        wait_pos(1, 1);
        strobe(8'h0F);
        wait_pos(4, 2);
        strobe(8'hF0);
        wait_pos(3, 2);
        chk("last_load_bit3", {31'd0, dinA}, 32'd0);
        wait_pos(4, 2);
        chk("last_load_bit4", {31'd0, dinA}, 32'd1);

        // Load coinciding with the slot-7 end beats the pending frame.
        wait_pos(2, 1);
        strobe(8'h11);
        wait_pos(7, 3);
        strobe(8'h22);
        wait_pos(1, 2);
        chk("coincide_bit1", {31'd0, dinA}, 32'd1);
        wait_pos(0, 2);
        chk("pending_cleared_bit0", {31'd0, dinA}, 32'd0);

        // Stop in slot 5: slot completes, then idle without frame_done.
        wait_pos(5, 1);
        run = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (fdA) cnt++;
        end
        chk("stop5_no_done", cnt, 0);
        chk("stop5_idle", {25'd0, selA, enA, dinA, busyA, fdA}, 32'd0);

        // Stop in slot 7: exactly one frame_done, then idle.
        run = 1'b1;
        wait_pos(7, 1);
        run = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (fdA) cnt++;
        end
        chk("stop7_one_done", cnt, 1);
        chk("stop7_idle_busy", {31'd0, busyA}, 32'd0);

        // Randomized run toggling and loads against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) run = ~run;
            load = ($urandom_range(0, 7) == 0);
            fdata = 8'($urandom);
            cyc();
        end
        load = 1'b0;

        // Asynchronous reset in the middle of a DRIVE cycle.
        run = 1'b1;
        strobe(8'hFF);
        wait_pos(0, 1);
        wait_pos(0, 1);
        wait_pos(2, 2);
        #1 reset_n = 1'b0;
        #1;
        chk("async_drop", {29'd0, enA, dinA, busyA}, 32'd0);
        mA = minit();
        mB = minit();
        #1 reset_n = 1'b1;
        cyc();
        chk("restart_slot0", {25'd0, selA, enA, dinA, busyA, fdA}, 32'h0000_0002);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (dinA || dinB) cnt++;
        end
        chk("restart_active_zero", cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
